// File: rtl/timing_loop_ctrl.sv
// Acquisition/tracking sequencer for the Gardner timing loop: grades mean |err|
// over fixed symbol windows and drives hold/reload/gain controls plus lock status.
module timing_loop_ctrl #(
  parameter int          WIN_LOG2    = 4,
  parameter int          CONFIRM     = 3,
  parameter logic [20:0] LOCK_THR    = 21'd512,
  parameter logic [20:0] UNLOCK_THR  = 21'd2048,
  parameter int          ACQ_TIMEOUT = 1024,
  parameter logic [3:0]  GAIN_ACQ    = 4'd6,
  parameter logic [3:0]  GAIN_TRK    = 4'd8,
  parameter logic [15:0] WN_INIT     = 16'h0147,
  parameter logic [15:0] WN_MIN      = 16'h0100,
  parameter logic [15:0] WN_MAX      = 16'h0190
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_sync_flag,
  input  logic [21:0] i_err,
  input  logic [15:0] i_wn_in,
  output logic        o_loop_hold,
  output logic        o_loop_load,
  output logic [15:0] o_wn_init,
  output logic [3:0]  o_gain_shift,
  output logic        o_lock,
  output logic [1:0]  o_state,
  output logic        o_acq_timeout,
  output logic        o_lock_lost
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RELOAD = 2'd1,
    ST_ACQ    = 2'd2,
    ST_TRACK  = 2'd3
  } state_t;

  localparam int ACC_W = 21 + WIN_LOG2;
  localparam int CNT_W = $clog2(CONFIRM + 1);
  localparam int SYM_W = $clog2(ACQ_TIMEOUT + 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST   = '1;
  localparam logic [CNT_W-1:0]    CONFIRM_M1 = CNT_W'(CONFIRM - 1);
  localparam logic [SYM_W-1:0]    TIMEOUT_M1 = SYM_W'(ACQ_TIMEOUT - 1);

  state_t              r_state;
  logic                r_hold;
  logic                r_load;
  logic [3:0]          r_gain;
  logic                r_lock;
  logic                r_acq_timeout;
  logic                r_lock_lost;
  logic [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [CNT_W-1:0]    r_good_cnt;
  logic [CNT_W-1:0]    r_bad_cnt;
  logic [SYM_W-1:0]    r_sym_cnt;

  state_t           w_next;
  logic             w_timeout;
  logic             w_lost;
  logic [20:0]      w_abs;
  logic [ACC_W-1:0] w_sum;
  logic [20:0]      w_mean;
  logic             w_win_end;
  logic             w_range_bad;
  logic             w_good;
  logic             w_bad;
  logic             w_run;

  // -2^21 has no 21-bit magnitude, so it saturates to the largest one.
  always_comb begin
    w_abs = i_err[20:0];
    if (i_err[21]) begin
      if (i_err[20:0] == 21'd0) w_abs = '1;
      else                      w_abs = ~i_err[20:0] + 21'd1;
    end
  end

  assign w_sum       = r_acc + ACC_W'(w_abs);
  assign w_mean      = w_sum[ACC_W-1:WIN_LOG2];
  assign w_win_end   = i_sync_flag && (r_win_cnt == WIN_LAST);
  assign w_range_bad = (i_wn_in < WN_MIN) || (i_wn_in > WN_MAX);
  assign w_good      = w_mean < LOCK_THR;
  assign w_bad       = w_mean > UNLOCK_THR;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_lost    = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_enable) w_next = ST_RELOAD;
      ST_RELOAD: w_next = i_enable ? ST_ACQ : ST_IDLE;
      ST_ACQ: begin
        if (!i_enable) begin
          w_next = ST_IDLE;
        end else if (i_sync_flag) begin
          if (w_range_bad) begin
            w_next = ST_RELOAD;
          end else if (w_win_end && w_good && (r_good_cnt == CONFIRM_M1)) begin
            w_next = ST_TRACK;
          end else if (r_sym_cnt == TIMEOUT_M1) begin
            w_next    = ST_RELOAD;
            w_timeout = 1'b1;
          end
        end
      end
      ST_TRACK: begin
        if (!i_enable) begin
          w_next = ST_IDLE;
        end else if (i_sync_flag) begin
          if (w_range_bad) begin
            w_next = ST_RELOAD;
          end else if (w_win_end && w_bad && (r_bad_cnt == CONFIRM_M1)) begin
            w_next = ST_RELOAD;
            w_lost = 1'b1;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counters only run while staying inside ACQ/TRACK; any other path clears them.
  assign w_run = ((r_state == ST_ACQ) || (r_state == ST_TRACK)) &&
                 ((w_next == ST_ACQ) || (w_next == ST_TRACK));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_hold        <= 1'b1;
      r_load        <= 1'b0;
      r_gain        <= GAIN_ACQ;
      r_lock        <= 1'b0;
      r_acq_timeout <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_acc         <= '0;
      r_win_cnt     <= '0;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_sym_cnt     <= '0;
    end else begin
      r_state       <= w_next;
      r_hold        <= (w_next == ST_IDLE) || (w_next == ST_RELOAD);
      r_load        <= (w_next == ST_RELOAD);
      r_gain        <= (w_next == ST_TRACK) ? GAIN_TRK : GAIN_ACQ;
      r_lock        <= (w_next == ST_TRACK);
      r_acq_timeout <= w_timeout;
      r_lock_lost   <= w_lost;
      if (!w_run) begin
        r_acc      <= '0;
        r_win_cnt  <= '0;
        r_good_cnt <= '0;
        r_bad_cnt  <= '0;
        r_sym_cnt  <= '0;
      end else if (i_sync_flag) begin
        if (w_win_end) begin
          r_acc     <= '0;
          r_win_cnt <= '0;
          if (r_state == ST_ACQ) r_good_cnt <= w_good ? r_good_cnt + CNT_W'(1) : '0;
          else                   r_bad_cnt  <= w_bad  ? r_bad_cnt  + CNT_W'(1) : '0;
        end else begin
          r_acc     <= w_sum;
          r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        end
        if (r_state == ST_ACQ) r_sym_cnt <= r_sym_cnt + SYM_W'(1);
      end
    end
  end

  assign o_state       = r_state;
  assign o_loop_hold   = r_hold;
  assign o_loop_load   = r_load;
  assign o_gain_shift  = r_gain;
  assign o_lock        = r_lock;
  assign o_acq_timeout = r_acq_timeout;
  assign o_lock_lost   = r_lock_lost;
  assign o_wn_init     = WN_INIT;

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Bench for timing_loop_ctrl: table of symbol phases plus hand-written corner sequences.
module tb_timing_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sync_flag;
  logic [21:0] err;
  logic [15:0] wn_in;
  logic        loop_hold;
  logic        loop_load;
  logic [15:0] wn_init;
  logic [3:0]  gain_shift;
  logic        lock;
  logic [1:0]  state;
  logic        acq_timeout;
  logic        lock_lost;

  timing_loop_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_sync_flag   (sync_flag),
    .i_err         (err),
    .i_wn_in       (wn_in),
    .o_loop_hold   (loop_hold),
    .o_loop_load   (loop_load),
    .o_wn_init     (wn_init),
    .o_gain_shift  (gain_shift),
    .o_lock        (lock),
    .o_state       (state),
    .o_acq_timeout (acq_timeout),
    .o_lock_lost   (lock_lost)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int load_seen = 0;
  logic [1:0] exp_q[$];   // expected pulses: 2'b01 acq_timeout, 2'b10 lock_lost

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard for status pulses, sampled 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (rst_n === 1'b1) begin
      if (acq_timeout || lock_lost) begin
        if (exp_q.size() == 0) check("unexpected pulse", {30'd0, lock_lost, acq_timeout}, 32'd0);
        else                   check("pulse", {30'd0, lock_lost, acq_timeout}, {30'd0, exp_q.pop_front()});
      end
      if (loop_load) load_seen++;
    end
  end

  // driver tasks
  task automatic send_sym(input logic [21:0] e, input logic [15:0] w);
    @(negedge clk);
    sync_flag = 1'b1;
    err       = e;
    wn_in     = w;
    @(negedge clk);
    sync_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [1:0] s, input logic l,
                            input logic [3:0] g, input logic h);
    check({tag, " state"}, {30'd0, state}, {30'd0, s});
    check({tag, " lock"}, {31'd0, lock}, {31'd0, l});
    check({tag, " gain"}, {28'd0, gain_shift}, {28'd0, g});
    check({tag, " hold"}, {31'd0, loop_hold}, {31'd0, h});
  endtask

  typedef struct {
    logic [21:0] err;
    logic        alt;
    logic [15:0] wn;
    int          nsym;
    logic [1:0]  exp_state;
    logic        exp_lock;
    logic [3:0]  exp_gain;
    logic        exp_hold;
    logic [1:0]  exp_pulse;
    int          exp_load;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{22'd100,     1'b1, 16'h0147, 47,   2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[1]  = '{22'd100,     1'b1, 16'h0147, 1,    2'd3, 1'b1, 4'd8, 1'b0, 2'b00, 0};
    vecs[2]  = '{22'h000400,  1'b0, 16'h0147, 48,   2'd3, 1'b1, 4'd8, 1'b0, 2'b00, 0};
    vecs[3]  = '{22'h001000,  1'b0, 16'h0147, 47,   2'd3, 1'b1, 4'd8, 1'b0, 2'b00, 0};
    vecs[4]  = '{22'h001000,  1'b0, 16'h0147, 1,    2'd1, 1'b0, 4'd6, 1'b1, 2'b10, 1};
    vecs[5]  = '{22'h010000,  1'b0, 16'h0147, 1023, 2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[6]  = '{22'h010000,  1'b0, 16'h0147, 1,    2'd1, 1'b0, 4'd6, 1'b1, 2'b01, 1};
    vecs[7]  = '{22'd100,     1'b1, 16'h0147, 32,   2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[8]  = '{22'h200000,  1'b0, 16'h0147, 16,   2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[9]  = '{22'd100,     1'b1, 16'h0147, 47,   2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[10] = '{22'd100,     1'b1, 16'h0147, 1,    2'd3, 1'b1, 4'd8, 1'b0, 2'b00, 0};
    vecs[11] = '{22'd100,     1'b1, 16'h0200, 1,    2'd1, 1'b0, 4'd6, 1'b1, 2'b00, 1};
    vecs[12] = '{22'd100,     1'b1, 16'h00FF, 1,    2'd1, 1'b0, 4'd6, 1'b1, 2'b00, 1};
    vecs[13] = '{22'd100,     1'b1, 16'h0100, 24,   2'd2, 1'b0, 4'd6, 1'b0, 2'b00, 0};
    vecs[14] = '{22'd100,     1'b1, 16'h0190, 24,   2'd3, 1'b1, 4'd8, 1'b0, 2'b00, 0};

    rst_n     = 1'b0;
    enable    = 1'b0;
    sync_flag = 1'b0;
    err       = '0;
    wn_in     = 16'h0147;
    idle(3);
    check_outs("reset", 2'd0, 1'b0, 4'd6, 1'b1);
    check("reset load", {31'd0, loop_load}, 32'd0);
    check("wn_init", {16'd0, wn_init}, 32'h0147);
    check("reset pulses", {30'd0, lock_lost, acq_timeout}, 32'd0);
    rst_n = 1'b1;
    send_sym(22'h000400, 16'h0147);
    check_outs("idle sync ignored", 2'd0, 1'b0, 4'd6, 1'b1);

    enable = 1'b1;
    idle(1);
    check_outs("reload", 2'd1, 1'b0, 4'd6, 1'b1);
    check("reload load", {31'd0, loop_load}, 32'd1);
    idle(1);
    check_outs("acq entry", 2'd2, 1'b0, 4'd6, 1'b0);
    check("acq load", {31'd0, loop_load}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      load_seen = 0;
      if (vecs[i].exp_pulse != 2'b00) exp_q.push_back(vecs[i].exp_pulse);
      for (int k = 0; k < vecs[i].nsym; k++)
        send_sym((vecs[i].alt && k[0]) ? -vecs[i].err : vecs[i].err, vecs[i].wn);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_lock,
                 vecs[i].exp_gain, vecs[i].exp_hold);
      check($sformatf("vec%0d loads", i), load_seen, vecs[i].exp_load);
      check($sformatf("vec%0d pulses drained", i), exp_q.size(), 32'd0);
    end

    // enable drop mid-window, coinciding with a wn range fault
    enable = 1'b0;
    idle(1);
    check_outs("disable", 2'd0, 1'b0, 4'd6, 1'b1);
    enable = 1'b1;
    idle(2);
    check("reenable state", {30'd0, state}, 32'd2);
    for (int k = 0; k < 8; k++) send_sym(22'h200000, 16'h0147);
    load_seen = 0;
    @(negedge clk);
    sync_flag = 1'b1;
    wn_in     = 16'h0200;
    enable    = 1'b0;
    @(negedge clk);
    sync_flag = 1'b0;
    wn_in     = 16'h0147;
    check_outs("disable beats range", 2'd0, 1'b0, 4'd6, 1'b1);
    check("disable no reload", load_seen, 32'd0);
    enable = 1'b1;
    idle(2);
    check("restart acq", {30'd0, state}, 32'd2);
    for (int k = 0; k < 47; k++) send_sym(k[0] ? -22'd100 : 22'd100, 16'h0147);
    check_outs("restart 47", 2'd2, 1'b0, 4'd6, 1'b0);
    send_sym(22'd100, 16'h0147);
    check_outs("restart 48", 2'd3, 1'b1, 4'd8, 1'b0);

    // confirming good window lands on the timeout symbol
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(2);
    load_seen = 0;
    for (int w = 0; w < 64; w++) begin
      for (int k = 0; k < 16; k++) begin
        if ((w % 3 != 0) || (w == 63)) send_sym(k[0] ? -22'd100 : 22'd100, 16'h0147);
        else                           send_sym(22'h010000, 16'h0147);
      end
      if (w == 62) check_outs("prio w62", 2'd2, 1'b0, 4'd6, 1'b0);
    end
    check_outs("prio confirm", 2'd3, 1'b1, 4'd8, 1'b0);
    check("prio no reload", load_seen, 32'd0);

    // reset while tracking
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outs("reset in track", 2'd0, 1'b0, 4'd6, 1'b1);
    check("reset in track load", {31'd0, loop_load}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("final pulse queue", exp_q.size(), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timing_loop_ctrl.md
Name: timing_loop_ctrl

Overview:
Acquisition/tracking sequencer for the Gardner symbol-timing recovery loop. It consumes the per-symbol timing error and the current loop-filter output (wn), and grades loop quality over fixed symbol windows. From that grading it drives hold, reload and gain-select controls back into the loop filter, and reports lock status. It runs in the 500 kHz symbol-processing domain, beside the TED and the NCO/interpolator.

Parameters:
WIN_LOG2, 4, log2 of symbols per grading window (window = 16 symbols)
CONFIRM, 3, consecutive good/bad windows needed to change lock state
LOCK_THR, 21'd512, window-mean |err| below which a window is good
UNLOCK_THR, 21'd2048, window-mean |err| above which a window is bad in TRACK
ACQ_TIMEOUT, 1024, symbols allowed in ACQ before a forced reload
GAIN_ACQ, 4'd6, loop gain shift in ACQ (c1 = 2^-6)
GAIN_TRK, 4'd8, loop gain shift in TRACK (c1 = 2^-8)
WN_INIT, 16'h0147, loop-filter reload value (approx. 1/100)
WN_MIN, 16'h0100, lowest legal wn
WN_MAX, 16'h0190, highest legal wn

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
enable  in  1  loop run request, level
sync_flag  in  1  one-cycle pulse per symbol; err and wn_in valid with it
err  in  22  signed Gardner timing error for the current symbol
wn_in  in  16  current loop-filter output (unsigned fraction)
loop_hold  out  1  freezes loop-filter update when high
loop_load  out  1  one-cycle pulse: loop filter loads wn_init, clears error history
wn_init  out  16  reload value (constant WN_INIT)
gain_shift  out  4  loop gain right-shift in use
lock  out  1  timing lock indicator
state  out  2  0 IDLE, 1 RELOAD, 2 ACQ, 3 TRACK
acq_timeout  out  1  one-cycle pulse on ACQ timeout
lock_lost  out  1  one-cycle pulse on TRACK to RELOAD

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. Every register updates only on the rising edge of clk.
- Reset values: state=IDLE, lock=0, loop_hold=1, loop_load=0, gain_shift=GAIN_ACQ, pulses=0, all counters and the accumulator=0. wn_init is always WN_INIT.
- Magnitude: |err| is 21-bit unsigned. err=-2^21 saturates to 2^21-1.
- Accumulator: width 21+WIN_LOG2. In ACQ/TRACK, each sync_flag adds |err| and increments win_cnt.
- Window end: on the sync_flag where win_cnt = 2^WIN_LOG2-1, mean = (acc+|err|)>>WIN_LOG2. Acc and win_cnt clear on that edge.
- Decision timing: the decision is taken on that same edge, so new state, lock and pulses are visible in the next cycle.
- IDLE: loop_hold=1, lock=0. When enable=1, go to RELOAD.
- RELOAD: lasts exactly 1 cycle.
  - loop_load=1, loop_hold=1, gain_shift=GAIN_ACQ.
  - Clears acc, win_cnt, good_cnt, bad_cnt and sym_cnt.
  - Next state: ACQ if enable=1, else IDLE.
- ACQ: loop_hold=0, gain_shift=GAIN_ACQ, lock=0. Each sync_flag increments sym_cnt.
  - Window mean < LOCK_THR: good_cnt++. Otherwise good_cnt=0.
  - good_cnt reaching CONFIRM: go to TRACK, lock=1, gain_shift=GAIN_TRK.
  - sym_cnt reaching ACQ_TIMEOUT without lock: go to RELOAD and pulse acq_timeout.
- TRACK: loop_hold=0, gain_shift=GAIN_TRK, lock=1.
  - Window mean > UNLOCK_THR: bad_cnt++. Otherwise bad_cnt=0.
  - bad_cnt reaching CONFIRM: go to RELOAD, pulse lock_lost, lock=0.
- Range check: in ACQ/TRACK, a sync_flag with wn_in < WN_MIN or wn_in > WN_MAX forces RELOAD. No acq_timeout or lock_lost pulse is raised, and lock drops.
- Priority, highest first, when events coincide on the same edge:
  1. enable=0: go to IDLE and clear all counters.
  2. wn range fault.
  3. Window decision. A confirming good window beats a timeout on the same symbol.
  4. Timeout.
- Status timing: lock follows state, registered. It never glitches during RELOAD, where lock=0.
- sync_flag handling outside ACQ/TRACK: ignored, no accumulation.
- Reset mid-operation: returns to reset values on the next edge regardless of state.

Test Plan:
- Reset while in TRACK -> next cycle state=0, lock=0, loop_hold=1, gain_shift=6, loop_load=0.
- Raise enable, then feed sync_flag with err alternating +100/-100 and wn_in=16'h0147 -> one loop_load pulse with state=1 for one cycle, then ACQ. After the 48th sync_flag, lock=1, state=3, gain_shift=8.
- In ACQ, hold err=22'h010000 constant -> acq_timeout pulses after the 1024th sync_flag, then RELOAD and ACQ again with loop_load=1 for one cycle.
- In TRACK, switch to err=22'h001000 -> lock_lost pulses after 48 symbols, then state=1 and lock=0. Switching to err=22'h000400 instead keeps lock.
- In ACQ, drive wn_in=16'h0200 with a sync_flag -> RELOAD next cycle with no timeout or lock_lost pulse. The same with wn_in=16'h00FF.
- Sixteen symbols of err=22'h200000 (-2^21) -> mean 2^21-1, window bad. Then drop enable mid-window -> IDLE next cycle. Re-enable and check that accumulation restarts from 0.
